// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU-side types: machine word, RAM status encoding,
//               memory arbiter grant states and the forced error load word.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the RAM model each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Which side currently owns the shared RAM port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    // Load value returned to the owner when a transaction is abandoned
    // after too many consecutive RAM errors.
    localparam word_t BAD_WORD = 32'hBAD0BAD0;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates one shared RAM port between an instruction fetch
//               side and a data side. A grant lasts until the RAM reports
//               ACCESS, the owner drops its request, or ERR_MAX consecutive
//               ERROR cycles are seen (forced completion with BAD_WORD).
//               One idle cycle always separates two transactions.
// Config      : MEM_ARBITER_RR_EN undefined -> data has fixed priority.
//               MEM_ARBITER_RR_EN defined   -> on contention the side not
//               last served wins; last-served updates on completion only.
// Ports       : CLK, RST (async, active-high)
//               iREN/iaddr -> iwait/iload        instruction side
//               dREN/dWEN/daddr/dstore -> dwait/dload   data side
//               ramREN/ramWEN/ramaddr/ramstore -> RAM, ramload/ramstate <- RAM
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ERR_MAX = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int CW = (ERR_MAX < 1) ? 1 : $clog2(ERR_MAX + 1);
    // Counter value at which one more ERROR cycle forces completion.
    localparam logic [CW-1:0] c_err_last = CW'((ERR_MAX < 1) ? 0 : ERR_MAX - 1);

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [CW-1:0]  r_errcnt;
    logic [CW-1:0]  w_errcnt_nxt;
    logic           w_dreq;
    logic           w_err_done;
`ifdef MEM_ARBITER_RR_EN
    logic           r_last_d;       // 1: data side served last
    logic           w_last_d_nxt;
`endif

    assign w_dreq     = dREN | dWEN;
    assign w_err_done = (ramstate == ERROR) && (r_errcnt == c_err_last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_errcnt <= '0;
`ifdef MEM_ARBITER_RR_EN
            r_last_d <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_errcnt <= w_errcnt_nxt;
`ifdef MEM_ARBITER_RR_EN
            r_last_d <= w_last_d_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_errcnt_nxt = '0;
`ifdef MEM_ARBITER_RR_EN
        w_last_d_nxt = r_last_d;
`endif
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = w_dreq;
        iload    = ramload;
        dload    = ramload;

        case (r_state)
            IDLE: begin
`ifdef MEM_ARBITER_RR_EN
                if (w_dreq && iREN) begin
                    w_state_nxt = r_last_d ? IGNT : DGNT;
                end else if (w_dreq) begin
                    w_state_nxt = DGNT;
                end else if (iREN) begin
                    w_state_nxt = IGNT;
                end
`else
                if (w_dreq) begin
                    w_state_nxt = DGNT;
                end else if (iREN) begin
                    w_state_nxt = IGNT;
                end
`endif
            end

            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    // Owner withdrew: abandon without a completion pulse.
                    w_state_nxt = IDLE;
                end else if ((ramstate == ACCESS) || w_err_done) begin
                    iwait       = 1'b0;
                    w_state_nxt = IDLE;
                    if (w_err_done) begin
                        iload = BAD_WORD;
                    end
`ifdef MEM_ARBITER_RR_EN
                    w_last_d_nxt = 1'b0;
`endif
                end else if (ramstate == ERROR) begin
                    w_errcnt_nxt = r_errcnt + 1'b1;
                end
            end

            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                // A simultaneous read and write is issued as a write.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!w_dreq) begin
                    w_state_nxt = IDLE;
                end else if ((ramstate == ACCESS) || w_err_done) begin
                    dwait       = 1'b0;
                    w_state_nxt = IDLE;
                    if (w_err_done) begin
                        dload = BAD_WORD;
                    end
`ifdef MEM_ARBITER_RR_EN
                    w_last_d_nxt = 1'b1;
`endif
                end else if (ramstate == ERROR) begin
                    w_errcnt_nxt = r_errcnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed scenarios are
//               followed by a randomized phase; every cycle is compared to a
//               transaction-level reference model (owner, consecutive error
//               run, last-served side).
// Config      : honours MEM_ARBITER_RR_EN in the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int          ERR_MAX  = 3;
    localparam logic [31:0] BAD      = 32'hBAD0BAD0;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(.ERR_MAX(ERR_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: 0 = nobody, 1 = instruction, 2 = data.
    int   m_owner  = 0;
    int   m_errs   = 0;
    logic m_last_d = 1'b0;

    // Values observed in the most recent cycle, for directed spot checks.
    logic        s_ren, s_wen, s_iw, s_dw;
    logic [31:0] s_addr, s_store, s_iload, s_dload;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_errs   = 0;
        m_last_d = 1'b0;
    endtask

    // One clock cycle: apply inputs just after a rising edge, compare at the
    // falling edge, advance the model at the next rising edge.
    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds,
                       input logic [1:0] rs, input logic [31:0] rl);
        logic        dreq, req, done, errdone;
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_load;
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
        @(negedge CLK);
        dreq    = dr | dw;
        req     = (m_owner == 1) ? ir : (m_owner == 2) ? dreq : 1'b0;
        errdone = req && (rs == 2'd3) && (m_errs + 1 == ERR_MAX);
        done    = req && ((rs == 2'd2) || errdone);
        e_load  = errdone ? BAD : rl;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
        e_iw  = ir;   e_dw  = dreq;
        if (m_owner == 1) begin
            e_addr = ia; e_ren = ir; e_iw = ir && !done;
        end else if (m_owner == 2) begin
            e_addr = da; e_store = ds; e_wen = dw; e_ren = dr && !dw;
            e_dw = dreq && !done;
        end
        s_ren = ramREN; s_wen = ramWEN; s_addr = ramaddr; s_store = ramstore;
        s_iw = iwait; s_dw = dwait; s_iload = iload; s_dload = dload;
        chk("ramREN",   {31'b0, ramREN}, {31'b0, e_ren});
        chk("ramWEN",   {31'b0, ramWEN}, {31'b0, e_wen});
        chk("ramaddr",  ramaddr,         e_addr);
        chk("ramstore", ramstore,        e_store);
        chk("iwait",    {31'b0, iwait},  {31'b0, e_iw});
        chk("dwait",    {31'b0, dwait},  {31'b0, e_dw});
        if (done && m_owner == 1) chk("iload", iload, e_load);
        if (done && m_owner == 2) chk("dload", dload, e_load);
        @(posedge CLK);
        if (m_owner == 0) begin
`ifdef MEM_ARBITER_RR_EN
            if (dreq && ir)  m_owner = m_last_d ? 1 : 2;
            else if (dreq)   m_owner = 2;
            else if (ir)     m_owner = 1;
`else
            if (dreq)        m_owner = 2;
            else if (ir)     m_owner = 1;
`endif
            m_errs = 0;
        end else begin
            if (done) m_last_d = (m_owner == 2);
            m_errs  = (req && !done && rs == 2'd3) ? m_errs + 1 : 0;
            if (!req || done) m_owner = 0;
        end
        #1;
    endtask

    initial begin
        iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = 0; RST = 1'b1;
        model_reset();

        // Reset state: RAM port quiet, waits follow the requests.
        repeat (2) @(posedge CLK);
        #1;
        iREN = 1; dWEN = 1; daddr = 32'h55; dstore = 32'h66;
        #1;
        chk("rst_ramREN",  {31'b0, ramREN}, 32'h0);
        chk("rst_ramWEN",  {31'b0, ramWEN}, 32'h0);
        chk("rst_ramaddr", ramaddr,         32'h0);
        chk("rst_iwait",   {31'b0, iwait},  32'h1);
        chk("rst_dwait",   {31'b0, dwait},  32'h1);
        iREN = 0; dWEN = 0;
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;

        // Instruction fetch, two BUSY then ACCESS.
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd0, 32'h0);
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 32'h0);
        chk("i_ren_c1", {31'b0, s_ren}, 32'h1);
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 32'h0);
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'h1234ABCD);
        chk("i_iwait_c3", {31'b0, s_iw}, 32'h0);
        chk("i_iload_c3", s_iload, 32'h1234ABCD);
        cyc(0, 32'h40, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("i_idle_c4", {31'b0, s_ren}, 32'h0);

        // Contention: data write wins, instruction follows after an idle cycle.
        cyc(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, 2'd0, 32'h0);
        cyc(1, 32'h44, 0, 1, 32'h80, 32'hDEADBEEF, 2'd2, 32'h0);
        chk("d_wen",   {31'b0, s_wen}, 32'h1);
        chk("d_store", s_store, 32'hDEADBEEF);
        chk("d_iwait", {31'b0, s_iw}, 32'h1);
        cyc(1, 32'h44, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("gap_ren", {31'b0, s_ren}, 32'h0);
        cyc(1, 32'h44, 0, 0, 0, 0, 2'd2, 32'h77);
        chk("i_after_d", s_addr, 32'h44);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);

        // Three consecutive ERROR cycles force completion with BAD word.
        cyc(0, 0, 1, 0, 32'h90, 0, 2'd0, 32'h0);
        cyc(0, 0, 1, 0, 32'h90, 0, 2'd3, 32'h1);
        chk("err1_dwait", {31'b0, s_dw}, 32'h1);
        cyc(0, 0, 1, 0, 32'h90, 0, 2'd3, 32'h2);
        cyc(0, 0, 1, 0, 32'h90, 0, 2'd3, 32'h3);
        chk("err3_dwait", {31'b0, s_dw}, 32'h0);
        chk("err3_dload", s_dload, BAD);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);

        // Data read dropped while BUSY aborts the grant.
        cyc(0, 0, 1, 0, 32'hA0, 0, 2'd0, 32'h0);
        cyc(0, 0, 1, 0, 32'hA0, 0, 2'd1, 32'h0);
        cyc(0, 0, 0, 0, 32'hA0, 0, 2'd1, 32'h0);
        chk("abort_ren", {31'b0, s_ren}, 32'h0);
        cyc(0, 0, 1, 0, 32'hA0, 0, 2'd2, 32'h0);
        chk("abort_idle_ren", {31'b0, s_ren}, 32'h0);
        chk("abort_idle_dw",  {31'b0, s_dw},  32'h1);

        // Reset pulsed during a BUSY data grant (model is now in DGNT).
        dREN = 1; dWEN = 0; daddr = 32'hB0; ramstate = 2'd1;
        #1;
        chk("pre_rst_ren", {31'b0, ramREN}, 32'h1);
        RST = 1'b1;
        #1;
        chk("mid_rst_ren",  {31'b0, ramREN}, 32'h0);
        chk("mid_rst_addr", ramaddr,         32'h0);
        chk("mid_rst_dw",   {31'b0, dwait},  32'h1);
        model_reset();
        @(negedge CLK); RST = 1'b0; dREN = 0;
        @(posedge CLK); #1;
        cyc(0, 0, 0, 0, 0, 0, 2'd2, 32'h0);

        // Randomized traffic against the reference model.
        begin
            logic ir, dr, dw;
            ir = 0; dr = 0; dw = 0;
            for (int k = 0; k < 2000; k++) begin
                if ($urandom_range(0, 7) == 0) ir = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 7) == 0) dr = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 7) == 0) dw = $urandom_range(0, 1) == 1;
                cyc(ir, $urandom, dr, dw, $urandom, $urandom,
                    2'($urandom_range(0, 3)), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ERR_MAX, default 3: consecutive ramstate ERROR cycles tolerated before forced completion.
REQ-002 SHALL have port CLK  in  1  clock, rising edge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports iREN in 1 instruction read request; iaddr in 32 instruction address.
REQ-005 SHALL have ports iwait out 1 instruction stall; iload out 32 instruction read data.
REQ-006 SHALL have ports dREN in 1, dWEN in 1 data read/write request; daddr in 32; dstore in 32 write data.
REQ-007 SHALL have ports dwait out 1 data stall; dload out 32 data read data.
REQ-008 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32: single shared RAM port.
REQ-009 SHALL have ports ramload in 32 RAM read data; ramstate in 2 RAM status (FREE=0, BUSY=1, ACCESS=2, ERROR=3).

Function
REQ-010 SHALL implement FSM states IDLE, IGNT, DGNT in a registered state.
REQ-011 IDLE: dREN|dWEN -> DGNT; else iREN -> IGNT; else stay; no RAM access driven in IDLE.
REQ-012 Grant latency: a request seen in IDLE SHALL drive the RAM port starting the next cycle.
REQ-013 DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (dREN+dWEN together treated as write).
REQ-014 IGNT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
REQ-015 Completion: in the granted state with ramstate==ACCESS, owner wait SHALL be 0 that same cycle, and FSM SHALL go IDLE next cycle.
REQ-016 iload and dload SHALL pass ramload combinationally; valid only in the owner's completion cycle.
REQ-017 iwait SHALL equal iREN except in the IGNT completion cycle; dwait SHALL equal dREN|dWEN except in the DGNT completion cycle.
REQ-018 Owner dropping its request before ACCESS SHALL abort: ram REN/WEN low that cycle, FSM to IDLE next cycle.
REQ-019 Error counter SHALL count consecutive ERROR cycles in a grant, clear on any other ramstate and on leaving the grant.
REQ-020 When the counter reaches ERR_MAX with ramstate==ERROR, the cycle SHALL count as completion, with owner load forced to 32'hBAD0BAD0.
REQ-021 One idle cycle SHALL separate back-to-back transactions; maximum throughput is one transaction per two RAM-ACCESS-limited periods.
REQ-022 RAM outputs SHALL be 0 whenever no grant is active.

Reset
REQ-023 RST SHALL force state IDLE, error counter 0, and last-served flag to instruction, asynchronously.
REQ-024 During reset: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=iREN, dwait=dREN|dWEN.
REQ-025 Reset asserted mid-grant SHALL abandon the transaction with no completion pulse.

Configuration
REQ-026 Macro MEM_ARBITER_RR_EN undefined: fixed priority, data over instruction (REQ-011).
REQ-027 MEM_ARBITER_RR_EN defined: if both sides request in IDLE, grant the side not last served; single requester granted directly; last-served flag updates on completion only.

Structure
REQ-028 arb_state_t (IDLE/IGNT/DGNT) and constant BAD_WORD=32'hBAD0BAD0 SHALL live in cpu_types_pkg beside the existing ramstate_t and word_t.
REQ-029 Single flat module with no sub-modules; the error counter is width $clog2(ERR_MAX+1).

Verification
REQ-030 iREN only, iaddr=0x40, ACCESS after 2 BUSY -> ramREN from cycle 1, iwait low in cycle 3, iload=ramload, IDLE in cycle 4.
REQ-031 iREN and dWEN together, daddr=0x80, dstore=0xDEADBEEF -> DGNT first, ramWEN=1, ramstore=0xDEADBEEF; IGNT follows after one idle cycle.
REQ-032 MEM_ARBITER_RR_EN, both sides requesting continuously -> grants alternate D,I,D,I.
REQ-033 ERR_MAX=3, ramstate held at ERROR -> third ERROR cycle completes with dload=0xBAD0BAD0, dwait=0.
REQ-034 dREN dropped while BUSY -> ramREN low in that cycle, IDLE next cycle, no completion pulse.
REQ-035 RST pulsed during DGNT BUSY -> RAM outputs 0 immediately, state IDLE, counter 0.
